mips_mem: RTL and testbench
===========================

# mips_mem

Word-organised memory responder that sits on the far side of the MIPS core's instruction and data buses. It returns instruction words for the fetch address, and it services data-port loads and stores. It also accepts a preload stream from the testbench or boot logic through a valid/ready handshake. With bounds checking compiled in, it flags illegal stores and fetches in a sticky fault register.

## Interface
Parameters:
- depth_words, 1024 — number of 32-bit words; power of two, ≥ 4.
- base_addr, 32'h0000_0000 — byte address of word 0; word-aligned.

Ports:
- clk  in  1  — single clock; all logic on posedge.
- reset  in  1  — synchronous, active-high.
- instr_addr  in  32  — byte fetch address from core PC.
- instr_data  out  32  — registered instruction word; drives core instr_in.
- data_addr  in  32  — byte data address from core.
- data_wr_data  in  32  — store data; driven by core data_out.
- data_rd_wr  in  1  — 1 = read, 0 = write (store this cycle).
- data_rd_data  out  32  — registered load data; drives core data_in.
- ld_valid  in  1  — preload word offered.
- ld_ready  out  1  — preload word accepted this cycle when high with ld_valid.
- ld_addr  in  log2(depth_words)  — preload word index.
- ld_data  in  32  — preload word.
- fault  out  1  — sticky illegal-access flag.
- fault_addr  out  32  — byte address of first faulting access.
- wr_count  out  16  — saturating count of committed core stores.

## Operation
- Index mapping: idx = (addr − base_addr) >> 2. addr[1:0] does not participate in the mapping.
- Reads: every non-reset cycle, instr_data ← mem[instr idx] and data_rd_data ← mem[data idx]. The data port reads even when data_rd_wr = 1 and the core ignores the result.
- Stores: a store commits at the edge when data_rd_wr = 0 and reset = 0. On commit, mem[data idx] ← data_wr_data and wr_count increments, saturating at 16'hFFFF.
- Write-first rule: a store and a read of the same index in the same cycle return the new data. This applies to both instr_data and data_rd_data.
- Preload:
  - ld_ready = !reset & data_rd_wr. A core store always wins the write port.
  - When ld_valid & ld_ready, mem[ld_addr] ← ld_data. The preload write does not increment wr_count.
  - The source holds ld_valid, ld_addr and ld_data stable until accepted.
  - Write-first also applies to a preload write colliding with a read of the same index.
- Fault FSM: two states, OK and FAULTED.
  - OK → FAULTED on the first illegal access; fault_addr captures that address.
  - FAULTED holds until reset. Later faults do not update fault_addr.
  - If a fetch fault and a store fault occur in the same cycle, fault_addr captures the data address.
- Reset:
  - instr_data = 0 (NOP), data_rd_data = 0, fault = 0, fault_addr = 0, wr_count = 0, ld_ready = 0.
  - Memory contents are not cleared. Preloaded images survive reset.
  - Reset asserted mid-handshake: the word is not accepted, and the source re-offers it after reset.

## Timing
- Read latency: 1 cycle. An address presented in cycle N yields data in cycle N+1.
- Store visible to a read of the same index issued in the same cycle (write-first) and in all later cycles.
- The fault flag and fault_addr update at the edge ending the faulting cycle, so fault = 1 in cycle N+1.
- ld_ready is combinational from reset and data_rd_wr. A transfer completes at the edge where both ld_valid and ld_ready are high.

## Configuration
- MIPS_MEM_BOUNDS_CHECK_EN defined:
  - An address is illegal if it is below base_addr, if idx ≥ depth_words, or if addr[1:0] ≠ 0.
  - An illegal store is suppressed: memory is unchanged, wr_count does not increment, and a fault is raised.
  - An illegal fetch returns 0 (NOP) and raises a fault.
  - An illegal data-port read returns 32'hDEAD_BEEF and raises no fault, because the core drives arbitrary data_addr on non-memory instructions.
- Not defined:
  - idx is taken modulo depth_words; wrap-around is silent.
  - fault and fault_addr are tied to 0.

## Test plan
- Reset, then preload idx 0..3 = 24090004, 24420008, AC430000, 8C440000 (ld_valid held, ld_ready high) → instr_addr 0,4,8,12 return those words one cycle later; instr_data = 0 during reset.
- Store data_addr 0x100, data_wr_data 0xCAFEF00D with the same address read that cycle → data_rd_data = 0xCAFEF00D next cycle; wr_count = 1.
- ld_valid with data_rd_wr = 0 for 3 cycles → ld_ready low, no preload write; accepted in the first cycle data_rd_wr = 1; the core store data is intact.
- Bounds on, store to 0xFFFF_FFF0 then fetch from 0x2 → memory unchanged, wr_count unchanged, fault = 1, fault_addr = 0xFFFF_FFF0 (first fault only); data read of 0xFFFF_FFF0 returns 0xDEAD_BEEF.
- Bounds off, depth_words = 1024, store 0x1234 to 0x1000 → read of 0x0000 returns 0x1234; fault stays 0.
- 65 540 consecutive stores → wr_count saturates at 0xFFFF; reset → wr_count = 0, memory contents retained.

Source files
------------

// File: rtl/mips_mem.sv
// Word-organised instruction/data memory for the MIPS core, with a preload port.
// Define MIPS_MEM_BOUNDS_CHECK_EN to add address checking and the sticky fault register.
//
// Fault FSM:
//   state       | meaning
//   st_ok       | no illegal access seen since reset
//   st_faulted  | an illegal store or fetch was seen; fault_addr holds the first one
module mips_mem #(
    parameter int          depth_words = 1024,
    parameter logic [31:0] base_addr   = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    instr_addr,
    output logic [31:0]                    instr_data,
    input  logic [31:0]                    data_addr,
    input  logic [31:0]                    data_wr_data,
    input  logic                           data_rd_wr,
    output logic [31:0]                    data_rd_data,
    input  logic                           ld_valid,
    output logic                           ld_ready,
    input  logic [$clog2(depth_words)-1:0] ld_addr,
    input  logic [31:0]                    ld_data,
    output logic                           fault,
    output logic [31:0]                    fault_addr,
    output logic [15:0]                    wr_count
);
    localparam int aw = $clog2(depth_words);

    logic [31:0]   mem [depth_words];
    logic [31:0]   instr_off;
    logic [31:0]   data_off;
    logic [aw-1:0] instr_idx;
    logic [aw-1:0] data_idx;
    logic          instr_legal;
    logic          data_legal;
    logic          store_en;
    logic          pre_en;
    logic [31:0]   instr_next;
    logic [31:0]   data_next;
    logic          unused_bits;

    assign instr_off = instr_addr - base_addr;
    assign data_off  = data_addr - base_addr;
    assign instr_idx = instr_off[aw+1:2];
    assign data_idx  = data_off[aw+1:2];

`ifdef MIPS_MEM_BOUNDS_CHECK_EN
    assign instr_legal = (instr_addr >= base_addr) && ((instr_off >> (aw + 2)) == 32'd0)
                         && (instr_addr[1:0] == 2'b00);
    assign data_legal  = (data_addr >= base_addr) && ((data_off >> (aw + 2)) == 32'd0)
                         && (data_addr[1:0] == 2'b00);
`else
    assign instr_legal = 1'b1;
    assign data_legal  = 1'b1;
`endif

    // Offset bits above the index (and the byte lane bits) only matter for bounds checking.
    assign unused_bits = ^{instr_off, data_off, instr_addr[1:0], data_addr[1:0]};

    assign ld_ready = !reset && data_rd_wr;
    assign store_en = !reset && !data_rd_wr && data_legal;
    assign pre_en   = ld_valid && ld_ready;

    always_ff @(posedge clk) begin
        if (store_en) begin
            mem[data_idx] <= data_wr_data;
        end else if (pre_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Write-first forwarding: a same-cycle write to the read index wins over the array.
    always_comb begin
        instr_next = mem[instr_idx];
        if (!instr_legal) begin
            instr_next = 32'h0000_0000;
        end else if (store_en && (data_idx == instr_idx)) begin
            instr_next = data_wr_data;
        end else if (pre_en && (ld_addr == instr_idx)) begin
            instr_next = ld_data;
        end

        data_next = mem[data_idx];
        if (!data_legal) begin
            data_next = 32'hDEAD_BEEF;
        end else if (store_en) begin
            data_next = data_wr_data;
        end else if (pre_en && (ld_addr == data_idx)) begin
            data_next = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_data   <= 32'h0000_0000;
            data_rd_data <= 32'h0000_0000;
            wr_count     <= 16'h0000;
        end else begin
            instr_data   <= instr_next;
            data_rd_data <= data_next;
            if (store_en && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

`ifdef MIPS_MEM_BOUNDS_CHECK_EN
    typedef enum logic {
        st_ok,
        st_faulted
    } fault_state_t;

    fault_state_t state;
    fault_state_t state_next;
    logic [31:0]  fault_addr_next;
    logic         fetch_fault;
    logic         store_fault;

    assign fetch_fault = !instr_legal;
    assign store_fault = !data_rd_wr && !data_legal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= st_ok;
            fault_addr <= 32'h0000_0000;
        end else begin
            state      <= state_next;
            fault_addr <= fault_addr_next;
        end
    end

    // Only the first fault is recorded; a simultaneous store fault takes priority.
    always_comb begin
        state_next      = state;
        fault_addr_next = fault_addr;
        case (state)
            st_ok: begin
                if (store_fault) begin
                    state_next      = st_faulted;
                    fault_addr_next = data_addr;
                end else if (fetch_fault) begin
                    state_next      = st_faulted;
                    fault_addr_next = instr_addr;
                end
            end
            st_faulted: state_next = st_faulted;
            default:    state_next = st_ok;
        endcase
    end

    assign fault = (state == st_faulted);
`else
    assign fault      = 1'b0;
    assign fault_addr = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_mips_mem.sv
// Self-checking bench for mips_mem: directed scenarios plus a randomized run
// against an array-based reference model of the memory, counter and fault flag.
module tb_mips_mem;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef MIPS_MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic        data_rd_wr;
    logic [31:0] data_rd_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic        fault;
    logic [31:0] fault_addr;
    logic [15:0] wr_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [DEPTH];
    int unsigned model_wr_count;
    logic        model_fault;
    logic [31:0] model_fault_addr;
    logic [31:0] exp_i;
    logic [31:0] exp_d;

    mips_mem #(.depth_words(DEPTH), .base_addr(BASE)) dut (
        .clk(clk), .reset(reset),
        .instr_addr(instr_addr), .instr_data(instr_data),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_rd_wr(data_rd_wr),
        .data_rd_data(data_rd_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .fault(fault), .fault_addr(fault_addr), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    function automatic bit legal(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < DEPTH) && (a[1:0] == 2'b00);
    endfunction

    function automatic int unsigned midx(input logic [31:0] a);
        return ((a - BASE) >> 2) % DEPTH;
    endfunction

    // Apply this cycle's effects to the model (writes before reads), then clock the DUT.
    task automatic tick();
        bit sf;
        bit ff;
        if (reset) begin
            exp_i = 32'h0;
            exp_d = 32'h0;
            model_wr_count = 0;
            model_fault = 1'b0;
            model_fault_addr = 32'h0;
        end else begin
            if (!data_rd_wr && (!BOUNDS || legal(data_addr))) begin
                model_mem[midx(data_addr)] = data_wr_data;
                if (model_wr_count < 32'hFFFF) model_wr_count++;
            end else if (data_rd_wr && ld_valid) begin
                model_mem[ld_addr] = ld_data;
            end
            exp_i = (BOUNDS && !legal(instr_addr)) ? 32'h0 : model_mem[midx(instr_addr)];
            exp_d = (BOUNDS && !legal(data_addr)) ? 32'hDEAD_BEEF : model_mem[midx(data_addr)];
            if (BOUNDS && !model_fault) begin
                sf = !data_rd_wr && !legal(data_addr);
                ff = !legal(instr_addr);
                if (sf || ff) begin
                    model_fault = 1'b1;
                    model_fault_addr = sf ? data_addr : instr_addr;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_addr = 32'h0; data_addr = 32'h0; data_wr_data = 32'h0; data_rd_wr = 1'b1;
        ld_valid = 1'b0; ld_addr = 10'd0; ld_data = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ld_ready got %b want 0", ld_ready); end
        tick();
        tick();
        n_cmp++;
        if (instr_data !== 32'h0) begin n_bad++; $display("FAIL reset_instr got %h want 0", instr_data); end
        n_cmp++;
        if (data_rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", data_rd_data); end
        n_cmp++;
        if (wr_count !== 16'h0) begin n_bad++; $display("FAIL reset_wr_count got %h want 0", wr_count); end
        n_cmp++;
        if (fault !== 1'b0 || fault_addr !== 32'h0) begin
            n_bad++; $display("FAIL reset_fault got %b/%h want 0/0", fault, fault_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_preload();
        logic [31:0] vals [4];
        vals[0] = 32'h2409_0004; vals[1] = 32'h2442_0008;
        vals[2] = 32'hAC43_0000; vals[3] = 32'h8C44_0000;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_addr = 10'(i); ld_data = vals[i]; data_rd_wr = 1'b1;
            instr_addr = 32'(i * 4);
            #1;
            n_cmp++;
            if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL preload_ready[%0d] got %b want 1", i, ld_ready); end
            tick();
            n_cmp++;
            if (instr_data !== vals[i]) begin
                n_bad++; $display("FAIL preload_write_first[%0d] got %h want %h", i, instr_data, vals[i]);
            end
        end
        ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            instr_addr = 32'(i * 4);
            tick();
            n_cmp++;
            if (instr_data !== vals[i]) begin
                n_bad++; $display("FAIL preload_fetch[%0d] got %h want %h", i, instr_data, vals[i]);
            end
        end
    endtask

    task automatic test_store_forward();
        data_rd_wr = 1'b0; data_addr = 32'h100; data_wr_data = 32'hCAFE_F00D; instr_addr = 32'h100;
        tick();
        data_rd_wr = 1'b1;
        n_cmp++;
        if (data_rd_data !== 32'hCAFE_F00D) begin
            n_bad++; $display("FAIL store_fwd_data got %h want cafef00d", data_rd_data);
        end
        n_cmp++;
        if (instr_data !== 32'hCAFE_F00D) begin
            n_bad++; $display("FAIL store_fwd_instr got %h want cafef00d", instr_data);
        end
        n_cmp++;
        if (wr_count !== 16'd1) begin n_bad++; $display("FAIL store_wr_count got %0d want 1", wr_count); end
        instr_addr = 32'h0;
    endtask

    task automatic test_ld_stall();
        logic [31:0] st [3];
        logic [31:0] newv;
        ld_valid = 1'b1; ld_addr = 10'd5; ld_data = 32'h1111_1111; data_rd_wr = 1'b1;
        tick();
        newv = $urandom();
        ld_addr = 10'd5; ld_data = newv; instr_addr = 32'd20;
        for (int i = 0; i < 3; i++) begin
            data_rd_wr = 1'b0; data_addr = 32'h300 + 32'(4 * i); st[i] = $urandom(); data_wr_data = st[i];
            #1;
            n_cmp++;
            if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d] got %b want 0", i, ld_ready); end
            tick();
            n_cmp++;
            if (instr_data !== 32'h1111_1111) begin
                n_bad++; $display("FAIL stall_no_write[%0d] got %h want 11111111", i, instr_data);
            end
        end
        data_rd_wr = 1'b1; data_addr = 32'h0;
        #1;
        n_cmp++;
        if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL stall_accept_ready got %b want 1", ld_ready); end
        tick();
        ld_valid = 1'b0;
        n_cmp++;
        if (instr_data !== newv) begin n_bad++; $display("FAIL stall_accept got %h want %h", instr_data, newv); end
        for (int i = 0; i < 3; i++) begin
            data_addr = 32'h300 + 32'(4 * i);
            tick();
            n_cmp++;
            if (data_rd_data !== st[i]) begin
                n_bad++; $display("FAIL stall_store_intact[%0d] got %h want %h", i, data_rd_data, st[i]);
            end
        end
        n_cmp++;
        if (wr_count !== 16'd4) begin n_bad++; $display("FAIL stall_wr_count got %0d want 4", wr_count); end
        instr_addr = 32'h0;
    endtask

    task automatic test_address_map();
        if (!BOUNDS) begin
            data_rd_wr = 1'b0; data_addr = 32'h1000; data_wr_data = 32'h1234;
            tick();
            data_rd_wr = 1'b1; data_addr = 32'h0000;
            tick();
            n_cmp++;
            if (data_rd_data !== 32'h1234) begin n_bad++; $display("FAIL wrap_read got %h want 1234", data_rd_data); end
            data_addr = 32'h0003; instr_addr = 32'h0002;
            tick();
            n_cmp++;
            if (data_rd_data !== 32'h1234 || instr_data !== 32'h1234) begin
                n_bad++; $display("FAIL byte_lane_ignored got %h/%h want 1234", data_rd_data, instr_data);
            end
            n_cmp++;
            if (fault !== 1'b0 || fault_addr !== 32'h0) begin
                n_bad++; $display("FAIL wrap_no_fault got %b/%h want 0/0", fault, fault_addr);
            end
            instr_addr = 32'h0; data_addr = 32'h0;
        end else begin
            logic [31:0] v;
            logic [31:0] cnt_before;
            v = $urandom();
            ld_valid = 1'b1; ld_addr = 10'd1020; ld_data = v;
            tick();
            ld_valid = 1'b0;
            cnt_before = 32'(model_wr_count);
            data_rd_wr = 1'b0; data_addr = 32'hFFFF_FFF0; data_wr_data = 32'h5555_AAAA;
            tick();
            n_cmp++;
            if (32'(wr_count) !== cnt_before) begin
                n_bad++; $display("FAIL bounds_wr_count got %0d want %0d", wr_count, cnt_before);
            end
            n_cmp++;
            if (fault !== 1'b1 || fault_addr !== 32'hFFFF_FFF0) begin
                n_bad++; $display("FAIL bounds_store_fault got %b/%h want 1/fffffff0", fault, fault_addr);
            end
            data_rd_wr = 1'b1; instr_addr = 32'h2;
            tick();
            n_cmp++;
            if (instr_data !== 32'h0 || data_rd_data !== 32'hDEAD_BEEF) begin
                n_bad++; $display("FAIL bounds_reads got %h/%h want 0/deadbeef", instr_data, data_rd_data);
            end
            n_cmp++;
            if (fault_addr !== 32'hFFFF_FFF0) begin
                n_bad++; $display("FAIL bounds_first_only got %h want fffffff0", fault_addr);
            end
            instr_addr = 32'h0; data_addr = 32'hFF0;
            tick();
            n_cmp++;
            if (data_rd_data !== v) begin n_bad++; $display("FAIL bounds_mem_unchanged got %h want %h", data_rd_data, v); end
            reset = 1'b1;
            tick();
            reset = 1'b0;
            instr_addr = 32'h6; data_rd_wr = 1'b0; data_addr = 32'h2001;
            tick();
            data_rd_wr = 1'b1; instr_addr = 32'h0; data_addr = 32'h0;
            n_cmp++;
            if (fault !== 1'b1 || fault_addr !== 32'h2001) begin
                n_bad++; $display("FAIL bounds_priority got %b/%h want 1/00002001", fault, fault_addr);
            end
        end
    endtask

    task automatic test_random();
        bit pending;
        pending = 1'b0;
        data_rd_wr = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ld_valid = 1'b1; ld_addr = 10'(i); ld_data = $urandom();
            tick();
        end
        ld_valid = 1'b0;
        for (int n = 0; n < 400; n++) begin
            data_addr  = BOUNDS ? 32'($urandom_range(0, DEPTH - 1) << 2) : 32'($urandom());
            instr_addr = BOUNDS ? 32'($urandom_range(0, DEPTH - 1) << 2) : 32'($urandom());
            if ($urandom_range(0, 3) == 0) instr_addr = data_addr;
            data_rd_wr = ($urandom_range(0, 2) != 0);
            data_wr_data = $urandom();
            if (!pending && $urandom_range(0, 1) == 1) begin
                pending = 1'b1;
                ld_addr = ($urandom_range(0, 1) == 1) ? 10'(midx(instr_addr)) : 10'($urandom_range(0, DEPTH - 1));
                ld_data = $urandom();
            end
            ld_valid = pending;
            if (pending && data_rd_wr) pending = 1'b0;
            tick();
            n_cmp++;
            if (instr_data !== exp_i || data_rd_data !== exp_d) begin
                n_bad++; $display("FAIL random_read[%0d] got %h/%h want %h/%h", n, instr_data, data_rd_data, exp_i, exp_d);
            end
            n_cmp++;
            if (wr_count !== model_wr_count[15:0] || fault !== model_fault || fault_addr !== model_fault_addr) begin
                n_bad++; $display("FAIL random_state[%0d] got %h/%b/%h want %h/%b/%h", n, wr_count, fault, fault_addr,
                                  model_wr_count[15:0], model_fault, model_fault_addr);
            end
        end
        ld_valid = 1'b0; data_rd_wr = 1'b1; instr_addr = 32'h0; data_addr = 32'h0;
    endtask

    task automatic test_reset_handshake();
        logic [31:0] oldv;
        logic [31:0] newv;
        oldv = model_mem[7];
        newv = ~oldv;
        reset = 1'b1; ld_valid = 1'b1; ld_addr = 10'd7; ld_data = newv; data_rd_wr = 1'b1;
        #1;
        n_cmp++;
        if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL rst_hs_ready got %b want 0", ld_ready); end
        tick();
        reset = 1'b0; ld_valid = 1'b0; instr_addr = 32'd28;
        tick();
        n_cmp++;
        if (instr_data !== oldv) begin n_bad++; $display("FAIL rst_hs_not_accepted got %h want %h", instr_data, oldv); end
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        n_cmp++;
        if (instr_data !== newv) begin n_bad++; $display("FAIL rst_hs_reoffer got %h want %h", instr_data, newv); end
        instr_addr = 32'h0;
    endtask

    task automatic test_saturate();
        data_rd_wr = 1'b0; data_addr = 32'h3F0; instr_addr = 32'h0;
        for (int i = 0; i < 65540; i++) begin
            data_wr_data = 32'(i);
            tick();
        end
        data_rd_wr = 1'b1;
        n_cmp++;
        if (wr_count !== 16'hFFFF) begin n_bad++; $display("FAIL saturate got %h want ffff", wr_count); end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (wr_count !== 16'h0 || fault !== 1'b0) begin
            n_bad++; $display("FAIL saturate_reset got %h/%b want 0/0", wr_count, fault);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (data_rd_data !== 32'd65539) begin
            n_bad++; $display("FAIL retain_after_reset got %h want %h", data_rd_data, 32'd65539);
        end
        n_cmp++;
        if (instr_data !== model_mem[0]) begin
            n_bad++; $display("FAIL retain_idx0 got %h want %h", instr_data, model_mem[0]);
        end
    endtask

    initial begin
        model_wr_count = 0;
        model_fault = 1'b0;
        model_fault_addr = 32'h0;
        test_reset();
        test_preload();
        test_store_forward();
        test_ld_stall();
        test_address_map();
        test_random();
        test_reset_handshake();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
